// File: rtl/uart_byte_rx.sv
// 8N1 UART receive deframer: two-flop input synchronizer, mid-bit sampling FSM,
// and a single-entry valid/ready holding register with frame/overrun error pulses.
module uart_byte_rx #(
    parameter int CLKS_PER_BIT = 32,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_next;
    logic [IDX_W-1:0]     bit_idx;
    logic [IDX_W-1:0]     bit_idx_next;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 rx_meta;
    logic                 rx_s;
    logic                 sample_bit;
    logic                 good_stop;
    logic                 bad_stop;

    // Synchronizer resets to the idle level so a reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt + CNT_W'(1);
        bit_idx_next = bit_idx;
        sample_bit   = 1'b0;
        good_stop    = 1'b0;
        bad_stop     = 1'b0;

        case (state)
            IDLE: begin
                cnt_next = '0;
                if (!rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    state_next   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_next   = '0;
                    sample_bit = 1'b1;
                    if (bit_idx == IDX_LAST) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                // Leaving at mid-stop gives half a bit of slack for the next start edge.
                if (cnt == BIT_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        good_stop  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        bad_stop   = 1'b1;
                        state_next = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                cnt_next = '0;
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            shift_reg <= '0;
        end else if (sample_bit) begin
            shift_reg[bit_idx] <= rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            m_data      <= '0;
            m_valid     <= 1'b0;
            busy        <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            busy        <= (state_next != IDLE);
            frame_err   <= bad_stop;
            overrun_err <= good_stop && m_valid && !m_ready;
            if (good_stop && (!m_valid || m_ready)) begin
                m_data  <= shift_reg;
                m_valid <= 1'b1;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx: drives 8N1 frames on rx at 32 clk/bit and
// checks byte timing, handshake, glitch rejection, error pulses and reset abort.
module tb_uart_byte_rx;

    logic       clk;
    logic       rstN;
    logic       rx;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       busy;
    logic       frame_err;
    logic       overrun_err;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int fall_cyc = 0;

    int n_valid = 0;
    int n_ferr = 0;
    int n_oerr = 0;
    int n_both = 0;
    int n_busy = 0;
    int n_unstable = 0;
    int ferr_cyc = 0;
    int oerr_cyc = 0;
    int acc_cyc[$];
    logic [7:0] acc_data[$];
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [7:0] pd = 8'h00;

    uart_byte_rx #(
        .CLKS_PER_BIT(32),
        .DATA_BITS(8)
    ) dut (
        .clk(clk),
        .rstN(rstN),
        .rx(rx),
        .m_data(m_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .busy(busy),
        .frame_err(frame_err),
        .overrun_err(overrun_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_valid) n_valid++;
        if (m_valid && m_ready) begin
            acc_cyc.push_back(cyc);
            acc_data.push_back(m_data);
        end
        if (frame_err) begin
            n_ferr++;
            ferr_cyc = cyc;
        end
        if (overrun_err) begin
            n_oerr++;
            oerr_cyc = cyc;
        end
        if (frame_err && overrun_err) n_both++;
        if (busy) n_busy++;
        if (pv && !pr && m_valid && (m_data !== pd)) n_unstable++;
        pv = m_valid;
        pr = m_ready;
        pd = m_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        fall_cyc = cyc;
        cycles(32);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cycles(32);
        end
        rx = stop_bit;
        cycles(32);
    endtask

    int a0, v0, f0, o0, b0, f1;
    logic [7:0] c3;

    initial begin
        rstN = 1'b0;
        rx = 1'b1;
        m_ready = 1'b1;
        cycles(3);
        @(negedge clk);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_overrun_err", 32'(overrun_err), 32'd0);
        cycles(1);
        rstN = 1'b1;
        cycles(5);

        // 1: single byte, m_ready high
        a0 = acc_cyc.size(); v0 = n_valid; f0 = n_ferr; o0 = n_oerr;
        send_frame(8'hA5, 1'b1);
        cycles(5);
        @(negedge clk);
        chk("t1_count", 32'(acc_cyc.size() - a0), 32'd1);
        chk("t1_data", 32'(acc_data[a0]), 32'hA5);
        chk("t1_latency", 32'(acc_cyc[a0] - fall_cyc), 32'd307);
        chk("t1_valid_width", 32'(n_valid - v0), 32'd1);
        chk("t1_no_ferr", 32'(n_ferr - f0), 32'd0);
        chk("t1_no_oerr", 32'(n_oerr - o0), 32'd0);
        chk("t1_busy_low", 32'(busy), 32'd0);
        cycles(1);

        // 2: 8-clock glitch rejected, then 0x3C
        a0 = acc_cyc.size(); b0 = n_busy;
        rx = 1'b0;
        cycles(8);
        rx = 1'b1;
        cycles(40);
        @(negedge clk);
        chk("t2_no_byte", 32'(acc_cyc.size() - a0), 32'd0);
        chk("t2_busy_cycles", 32'(n_busy - b0), 32'd16);
        chk("t2_busy_low", 32'(busy), 32'd0);
        cycles(1);
        send_frame(8'h3C, 1'b1);
        cycles(5);
        chk("t2_count", 32'(acc_cyc.size() - a0), 32'd1);
        chk("t2_data", 32'(acc_data[a0]), 32'h3C);
        chk("t2_latency", 32'(acc_cyc[a0] - fall_cyc), 32'd307);

        // 3: bad stop bit, line held low
        a0 = acc_cyc.size(); f0 = n_ferr; o0 = n_oerr;
        send_frame(8'h3C, 1'b0);
        cycles(100);
        @(negedge clk);
        chk("t3_ferr_count", 32'(n_ferr - f0), 32'd1);
        chk("t3_ferr_time", 32'(ferr_cyc - fall_cyc), 32'd307);
        chk("t3_no_byte", 32'(acc_cyc.size() - a0), 32'd0);
        chk("t3_no_oerr", 32'(n_oerr - o0), 32'd0);
        chk("t3_busy_held", 32'(busy), 32'd1);
        cycles(1);
        rx = 1'b1;
        cycles(5);
        @(negedge clk);
        chk("t3_busy_released", 32'(busy), 32'd0);
        cycles(1);

        // 4: overrun with m_ready low
        m_ready = 1'b0;
        o0 = n_oerr; f0 = n_ferr;
        send_frame(8'h11, 1'b1);
        cycles(5);
        @(negedge clk);
        chk("t4_valid_first", 32'(m_valid), 32'd1);
        chk("t4_data_first", 32'(m_data), 32'h11);
        cycles(1);
        send_frame(8'h22, 1'b1);
        cycles(5);
        @(negedge clk);
        chk("t4_oerr_count", 32'(n_oerr - o0), 32'd1);
        chk("t4_oerr_time", 32'(oerr_cyc - fall_cyc), 32'd307);
        chk("t4_no_ferr", 32'(n_ferr - f0), 32'd0);
        chk("t4_valid_held", 32'(m_valid), 32'd1);
        chk("t4_data_held", 32'(m_data), 32'h11);
        cycles(1);
        a0 = acc_cyc.size();
        m_ready = 1'b1;
        cycles(1);
        m_ready = 1'b0;
        @(negedge clk);
        chk("t4_valid_drop", 32'(m_valid), 32'd0);
        chk("t4_data_not_new", 32'(m_data), 32'h11);
        chk("t4_accepted", 32'(acc_data[a0]), 32'h11);
        chk("t4_stable", 32'(n_unstable), 32'd0);
        cycles(1);
        m_ready = 1'b1;
        cycles(2);

        // 5: back-to-back frames
        a0 = acc_cyc.size();
        send_frame(8'h00, 1'b1);
        f1 = fall_cyc;
        send_frame(8'hFF, 1'b1);
        send_frame(8'h5A, 1'b1);
        cycles(5);
        chk("t5_count", 32'(acc_cyc.size() - a0), 32'd3);
        chk("t5_data0", 32'(acc_data[a0]), 32'h00);
        chk("t5_data1", 32'(acc_data[a0 + 1]), 32'hFF);
        chk("t5_data2", 32'(acc_data[a0 + 2]), 32'h5A);
        chk("t5_latency", 32'(acc_cyc[a0] - f1), 32'd307);
        chk("t5_gap01", 32'(acc_cyc[a0 + 1] - acc_cyc[a0]), 32'd320);
        chk("t5_gap12", 32'(acc_cyc[a0 + 2] - acc_cyc[a0 + 1]), 32'd320);

        // 6: reset during data bit 4 of 0xC3 (transmitter also abandons the frame)
        a0 = acc_cyc.size(); f0 = n_ferr; o0 = n_oerr;
        c3 = 8'hC3;
        rx = 1'b0;
        fall_cyc = cyc;
        cycles(32);
        for (int i = 0; i < 4; i++) begin
            rx = c3[i];
            cycles(32);
        end
        rx = c3[4];
        cycles(5);
        @(negedge clk);
        chk("t6_busy_mid", 32'(busy), 32'd1);
        cycles(1);
        rstN = 1'b0;
        cycles(1);
        rstN = 1'b1;
        rx = 1'b1;
        @(negedge clk);
        chk("t6_rst_valid", 32'(m_valid), 32'd0);
        chk("t6_rst_data", 32'(m_data), 32'h00);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_ferr", 32'(frame_err), 32'd0);
        chk("t6_rst_oerr", 32'(overrun_err), 32'd0);
        cycles(400);
        chk("t6_no_byte", 32'(acc_cyc.size() - a0), 32'd0);
        chk("t6_no_errs", 32'((n_ferr - f0) + (n_oerr - o0)), 32'd0);
        send_frame(8'h5A, 1'b1);
        cycles(5);
        chk("t6_count", 32'(acc_cyc.size() - a0), 32'd1);
        chk("t6_data", 32'(acc_data[a0]), 32'h5A);
        chk("t6_latency", 32'(acc_cyc[a0] - fall_cyc), 32'd307);

        chk("never_both_errs", 32'(n_both), 32'd0);
        chk("data_stable", 32'(n_unstable), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
UART receive deframer at the serial input of chip_top. It takes the raw asynchronous `rx` pin and recovers 8N1 bytes: 1 start bit, 8 data bits LSB first, 1 stop bit. Each recovered byte is presented on a valid/ready byte interface to the downstream pixel line-buffer / edge pipeline. Bit timing is derived from a fixed clocks-per-bit count: 32 at the system 10 ns clock, i.e. a 320 ns bit.

Parameters:
CLKS_PER_BIT, 32, system clocks per UART bit; legal range >= 4, even.
DATA_BITS, 8, data bits per frame; fixed at 8 for chip_top.

Ports:
clk  input  1  system clock; all logic on rising edge
rstN  input  1  reset, synchronous, active-low
rx  input  1  asynchronous serial line, idle high
m_data  output  8  received byte
m_valid  output  1  m_data holds an unconsumed byte
m_ready  input  1  downstream accepts byte when m_valid && m_ready
busy  output  1  high whenever FSM not in IDLE
frame_err  output  1  1-cycle pulse: stop bit sampled low
overrun_err  output  1  1-cycle pulse: good byte dropped because holding register full

Behaviour:
- Interface: one clock `clk`; reset `rstN` is synchronous and active-low.
- Reset: when rstN=0 at a clk edge:
  - sync flops <= 1; FSM <= IDLE; counters <= 0.
  - m_data <= 8'h00; m_valid, busy, frame_err, overrun_err <= 0.
  - Reset mid-frame aborts the frame silently; no partial byte, no error pulse.
- Input sync: rx passes through 2 flops to give rx_s (2-cycle lag). The FSM uses only rx_s.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE. The bit counter counts 0..CLKS_PER_BIT-1.
- IDLE: rx_s=0 -> START with cnt=0. Call this cycle T0.
- START: at cnt=CLKS_PER_BIT/2-1 (sample at T0+CLKS_PER_BIT/2), sample rx_s:
  - 0 -> DATA, cnt=0, bit_idx=0.
  - 1 -> IDLE (glitch rejected; no output, no error).
- DATA: at cnt=CLKS_PER_BIT-1, shift_reg[bit_idx] <= rx_s.
  - bit_idx 0..7; data bit k is sampled at T0+CLKS_PER_BIT/2+(k+1)*CLKS_PER_BIT.
  - After bit 7 -> STOP, cnt=0.
- STOP: sample at cnt=CLKS_PER_BIT-1, i.e. T0+CLKS_PER_BIT/2+9*CLKS_PER_BIT (T0+304 at default).
  - rx_s=1 -> byte good -> IDLE. Going to IDLE at mid-stop allows back-to-back frames.
  - rx_s=0 -> frame_err pulse, byte discarded -> WAIT_IDLE.
- WAIT_IDLE: remain until rx_s=1, then -> IDLE. Break/stuck-low conditions never produce bytes.
- Byte delivery, evaluated on the good-stop cycle:
  - If !m_valid, or m_valid && m_ready in that same cycle: load m_data, set m_valid=1 on the next edge. At default, m_valid rises at T0+305, i.e. 307 cycles after the rx pin falls.
  - If m_valid && !m_ready: overrun_err pulse; m_data keeps the old byte; the new byte is dropped.
- Handshake:
  - m_valid clears on the edge after m_valid && m_ready unless a new byte loads in the same cycle.
  - m_data is stable while m_valid && !m_ready.
  - m_valid never depends combinationally on m_ready.
- busy = (state != IDLE), registered.
- frame_err and overrun_err are never both high; each is high for exactly 1 cycle per event.

Test Plan:
1. Reset, m_ready=1, send 0xA5 at 320 ns/bit -> m_valid high exactly 1 cycle with m_data=0xA5, 307 clk after the rx falling edge; busy low afterwards; no error pulses.
2. rx low for 8 clk, then high -> no m_valid; busy high about 16 cycles, then low; FSM back in IDLE; a following frame 0x3C is received correctly.
3. Send 0x3C with stop bit 0, rx held low 100 more clk -> single frame_err pulse at stop sample; no m_valid; busy stays high until rx returns high.
4. m_ready=0, send 0x11 then 0x22 -> m_valid=1 with m_data=0x11 throughout; overrun_err pulse at the second stop sample; then m_ready=1 for 1 cycle -> m_valid drops, m_data is not 0x22.
5. Back-to-back 0x00, 0xFF, 0x5A with one stop bit each and no idle, m_ready=1 -> three m_valid pulses exactly 320 clk apart with data 0x00, 0xFF, 0x5A.
6. rstN=0 for 1 clk during data bit 4 of 0xC3 -> all outputs 0 after the edge; no byte emitted for the aborted frame; next frame 0x5A is received correctly.
